// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared store codes, MMIO offsets, default MMIO base and region type
package data_mem_responder_pkg;
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [1:0] OFF_CYCLE_LO = 2'd0;
  localparam logic [1:0] OFF_CYCLE_HI = 2'd1;
  localparam logic [1:0] OFF_LED = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;
  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF0000;
  typedef enum logic [1:0] {RegionRam, RegionMmio, RegionNone} regionT;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: M-stage data port between core (master) and memory responder (slave)
//   MemWriteM store strobe, ALUResultM byte address, WriteDataM raw rs2, InstrM funct3,
//   MemDataM aligned read word, MisalignM misaligned/illegal store flag
interface data_mem_responder_if;
  logic MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0] InstrM;
  logic [31:0] MemDataM;
  logic MisalignM;
  modport master(output MemWriteM, ALUResultM, WriteDataM, InstrM, input MemDataM, MisalignM);
  modport slave(input MemWriteM, ALUResultM, WriteDataM, InstrM, output MemDataM, MisalignM);
endinterface

// File: rtl/data_mem_responder_storeenc.sv
// data_mem_responder_storeenc: lane-aligns store data and builds byte enables (mirror of loaddec)
//   InstrM funct3, addrLo address bits [1:0], WriteDataM raw rs2 ->
//   be byte enables (zero when misaligned), wdata lane-replicated data, misalign size/alignment fault
module data_mem_responder_storeenc
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  InstrM,
  input  logic [1:0]  addrLo,
  input  logic [31:0] WriteDataM,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);
  logic [1:0] size;
  logic unusedInstr;
  assign size = InstrM[1:0];
  // funct3[2] only distinguishes unsigned loads; stores ignore it
  assign unusedInstr = InstrM[2];
  always_comb begin
    misalign = size == 2'b11 || (size == SH[1:0] && addrLo[0]) || (size == SW[1:0] && addrLo != 2'b00);
    be = misalign ? 4'b0000 : size == SB[1:0] ? 4'b0001 << addrLo : size == SH[1:0] ? (addrLo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = size == SB[1:0] ? {4{WriteDataM[7:0]}} : size == SH[1:0] ? {2{WriteDataM[15:0]}} : WriteDataM;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: M-stage data RAM plus MMIO page (cycle counter, LED, sticky error status)
//   clk, reset (async active-low), bus (slave modport of data_mem_responder_if),
//   ErrSticky registered sticky error flag, LedOut LED register contents
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus,
  output logic ErrSticky,
  output logic [31:0] LedOut
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  logic [31:0] mem [0:DEPTH-1];
  logic [63:0] cycleCnt;
  logic [AW-1:0] idx;
  logic [1:0] off;
  logic [3:0] be;
  logic [31:0] wdata;
  logic [31:0] mmioRd;
  logic misalign;
  logic storeOk;
  logic mmioWr;
  logic cntClr;
  logic ledWr;
  logic stClr;
  regionT region;
  data_mem_responder_storeenc storeEnc (
    .InstrM(bus.InstrM),
    .addrLo(bus.ALUResultM[1:0]),
    .WriteDataM(bus.WriteDataM),
    .be(be),
    .wdata(wdata),
    .misalign(misalign)
  );
  assign idx = bus.ALUResultM[AW+1:2];
  assign off = bus.ALUResultM[3:2];
  assign storeOk = bus.MemWriteM & ~misalign;
  assign bus.MisalignM = bus.MemWriteM & misalign;
  always_comb begin
    region = bus.ALUResultM < RAM_BYTES ? RegionRam : bus.ALUResultM[31:4] == MMIO_BASE[31:4] ? RegionMmio : RegionNone;
    mmioRd = off == OFF_CYCLE_LO ? cycleCnt[31:0] : off == OFF_CYCLE_HI ? cycleCnt[63:32] : off == OFF_LED ? LedOut : {31'h0, ErrSticky};
    mmioWr = storeOk && region == RegionMmio;
    cntClr = mmioWr && (off == OFF_CYCLE_LO || off == OFF_CYCLE_HI);
    ledWr = mmioWr && off == OFF_LED;
    // only lane 0 carries the clear bit; a sb to +D leaves it disabled
    stClr = mmioWr && off == OFF_STATUS && be[0] && wdata[0];
    bus.MemDataM = region == RegionRam ? mem[idx] : region == RegionMmio ? mmioRd : 32'h0;
  end
  // RAM has no reset, but a store landing while reset is held is dropped
  always_ff @(posedge clk)
    if (reset && storeOk && region == RegionRam)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i+:8] <= wdata[8*i+:8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycleCnt <= 64'h0;
      LedOut <= 32'h0;
      ErrSticky <= 1'b0;
    end else begin
      cycleCnt <= cntClr ? 64'h0 : cycleCnt + 64'h1;
      // a new fault outranks a same-edge clear
      ErrSticky <= bus.MisalignM | (ErrSticky & ~stClr);
      for (int i = 0; i < 4; i++)
        if (ledWr && be[i]) LedOut[8*i+:8] <= wdata[8*i+:8];
    end
endmodule
